// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the fetch PC and serves instructions from a
// direct-mapped, one-word-per-line cache that refills from the memory controller.
module inst_fetch #(
  parameter int unsigned IDX_BITS = 4,
  parameter logic [31:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        need_inst,
  output logic [31:0] pc,
  output logic [31:0] inst_out,
  output logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int unsigned LINES    = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = 30 - IDX_BITS;

  typedef enum logic {FETCH, MISS} state_t;

  state_t state, state_n;

  logic [31:0]         data_mem [LINES];
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINES-1:0]    valid;

  logic [IDX_BITS-1:0] look_idx, fill_idx;
  logic [TAG_BITS-1:0] look_tag, fill_tag;
  logic                hit;
  logic                fill;

  logic [31:0] pc_n, inst_n, maddr_n;
  logic        ready_n, req_n;

  assign look_idx = pc[IDX_BITS+1:2];
  assign look_tag = pc[31:IDX_BITS+2];
  assign fill_idx = mem_addr[IDX_BITS+1:2];
  assign fill_tag = mem_addr[31:IDX_BITS+2];
  assign hit      = valid[look_idx] && (tag_mem[look_idx] == look_tag);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst_out;
    ready_n = inst_ready;
    req_n   = mem_req;
    maddr_n = mem_addr;
    fill    = 1'b0;
    case (state)
      FETCH: begin
        // A redirect discards both a pending acceptance and this cycle's lookup.
        if (flush) begin
          pc_n    = flush_addr & ~32'h3;
          ready_n = 1'b0;
        end else if (redirect) begin
          pc_n    = redirect_addr & ~32'h3;
          ready_n = 1'b0;
        end else if (inst_ready) begin
          if (!need_inst) begin
            pc_n    = pc + 32'd4;
            ready_n = 1'b0;
          end
        end else if (hit) begin
          inst_n  = data_mem[look_idx];
          ready_n = 1'b1;
        end else begin
          req_n   = 1'b1;
          maddr_n = pc & ~32'h3;
          state_n = MISS;
        end
      end
      MISS: begin
        // The refill is still valid for mem_addr even if the PC moved meanwhile.
        if (mem_valid) begin
          fill    = 1'b1;
          req_n   = 1'b0;
          state_n = FETCH;
        end
        if (flush) begin
          pc_n    = flush_addr & ~32'h3;
          ready_n = 1'b0;
        end else if (redirect) begin
          pc_n    = redirect_addr & ~32'h3;
          ready_n = 1'b0;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_out   <= '0;
      inst_ready <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      valid      <= '0;
    end else if (rdy) begin
      state      <= state_n;
      pc         <= pc_n;
      inst_out   <= inst_n;
      inst_ready <= ready_n;
      mem_req    <= req_n;
      mem_addr   <= maddr_n;
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      data_mem[fill_idx] <= mem_data;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a cycle table for reset/hit/miss/redirect
// basics, then hand-written sequences for streaming hits, aliasing and freeze.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, need_inst, redirect, flush, mem_valid;
  logic [31:0] redirect_addr, flush_addr, mem_data;
  logic [31:0] pc, inst_out, mem_addr;
  logic        inst_ready, mem_req;

  int checks = 0;
  int errors = 0;
  logic mem_auto = 1'b0;
  int   lat_cnt  = 0;

  always #5 clk = ~clk;

  inst_fetch #(.IDX_BITS(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .need_inst(need_inst),
    .pc(pc), .inst_out(inst_out), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .flush(flush), .flush_addr(flush_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data)
  );

  typedef struct {
    logic        rst, rdy, need, redir;
    logic [31:0] raddr;
    logic        flush;
    logic [31:0] faddr;
    logic        mval;
    logic [31:0] mdata;
    logic [31:0] e_pc, e_inst;
    logic        e_rdy, e_req;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [31:0] model(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!inst_ready && n < 40) begin
      tick();
      n++;
    end
    chk("wait_ready", {31'd0, inst_ready}, 32'd1);
  endtask

  // Memory responder with 3-cycle latency, active only when mem_auto is set.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mem_auto) begin
        if (mem_valid) begin
          mem_valid = 1'b0;
        end else if (rdy && mem_req) begin
          lat_cnt++;
          if (lat_cnt >= 3) begin
            mem_valid = 1'b1;
            mem_data  = model(mem_addr);
            lat_cnt   = 0;
          end
        end else begin
          lat_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   rdy   need  redir raddr         flush faddr         mval  mdata          e_pc          e_inst         e_rdy e_req e_maddr
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h0,         1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h0,         1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h0,         1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h0,         1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00500093,  32'h0,        32'h0,         1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h00500093,  1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h00500093,  1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h4,        32'h00500093,  1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h4,        32'h00500093,  1'b0, 1'b1, 32'h4};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h11111111,  32'h4,        32'h00500093,  1'b0, 1'b0, 32'h4};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h4,        32'h11111111,  1'b1, 1'b0, 32'h4};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h300,      1'b1, 32'h200,      1'b0, 32'h0,         32'h200,      32'h11111111,  1'b0, 1'b0, 32'h4};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h103,      1'b0, 32'h0,        1'b0, 32'h0,         32'h100,      32'h11111111,  1'b0, 1'b0, 32'h4};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h100,      32'h11111111,  1'b0, 1'b1, 32'h100};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF,  32'h100,      32'h11111111,  1'b0, 1'b1, 32'h100};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h22222222,  32'h100,      32'h11111111,  1'b0, 1'b0, 32'h100};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h100,      32'h22222222,  1'b1, 1'b0, 32'h100};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h0,         1'b0, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        32'h0,         1'b0, 1'b1, 32'h0};

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst;  rdy = vecs[i].rdy;  need_inst = vecs[i].need;
      redirect = vecs[i].redir;  redirect_addr = vecs[i].raddr;
      flush = vecs[i].flush;  flush_addr = vecs[i].faddr;
      mem_valid = vecs[i].mval;  mem_data = vecs[i].mdata;
      tick();
      chk($sformatf("vec%0d.pc", i),       pc,                   vecs[i].e_pc);
      chk($sformatf("vec%0d.inst", i),     inst_out,             vecs[i].e_inst);
      chk($sformatf("vec%0d.ready", i),    {31'd0, inst_ready},  {31'd0, vecs[i].e_rdy});
      chk($sformatf("vec%0d.mem_req", i),  {31'd0, mem_req},     {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d.mem_addr", i), mem_addr,             vecs[i].e_maddr);
    end

    // Warm lines 0x0..0x3C through the auto responder.
    rst = 1'b1; rdy = 1'b1; need_inst = 1'b1; redirect = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    tick();
    rst = 1'b0; mem_auto = 1'b1;
    for (int a = 0; a <= 32'h3C; a += 4) begin
      wait_ready();
      chk("warm.pc", pc, a);
      chk("warm.inst", inst_out, model(a));
      if (a < 32'h3C) begin
        need_inst = 1'b0; tick(); need_inst = 1'b1;
      end
    end
    mem_auto = 1'b0;

    // Streaming hits: one instruction every two cycles, no refill.
    redirect = 1'b1; redirect_addr = 32'h4; tick(); redirect = 1'b0;
    chk("stream.redir_pc", pc, 32'h4);
    chk("stream.redir_ready", {31'd0, inst_ready}, 32'd0);
    tick();
    chk("stream.first_inst", inst_out, model(32'h4));
    chk("stream.first_ready", {31'd0, inst_ready}, 32'd1);
    for (int a = 4; a <= 32'h38; a += 4) begin
      need_inst = 1'b0; tick(); need_inst = 1'b1;
      chk("stream.acc_ready", {31'd0, inst_ready}, 32'd0);
      chk("stream.acc_pc", pc, a + 4);
      tick();
      chk("stream.hit_ready", {31'd0, inst_ready}, 32'd1);
      chk("stream.hit_inst", inst_out, model(a + 4));
      chk("stream.no_req", {31'd0, mem_req}, 32'd0);
    end
    need_inst = 1'b0; tick(); need_inst = 1'b1;
    chk("alias.pc", pc, 32'h40);
    tick();
    chk("alias.req", {31'd0, mem_req}, 32'd1);
    chk("alias.addr", mem_addr, 32'h40);

    // Fill 0x40, then force a miss at 0x8 by aliasing line 2 with 0x48.
    tick(); tick();
    chk("miss40.held", mem_addr, 32'h40);
    mem_valid = 1'b1; mem_data = model(32'h40); tick(); mem_valid = 1'b0;
    chk("miss40.req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    chk("miss40.inst", inst_out, model(32'h40));
    redirect = 1'b1; redirect_addr = 32'h48; tick(); redirect = 1'b0;
    tick();
    chk("miss48.addr", mem_addr, 32'h48);
    mem_valid = 1'b1; mem_data = model(32'h48); tick(); mem_valid = 1'b0;
    tick();
    chk("miss48.inst", inst_out, model(32'h48));
    redirect = 1'b1; redirect_addr = 32'h8; tick(); redirect = 1'b0;
    tick();
    chk("miss8.req", {31'd0, mem_req}, 32'd1);
    chk("miss8.addr", mem_addr, 32'h8);
    redirect = 1'b1; redirect_addr = 32'h103; tick(); redirect = 1'b0;
    chk("miss8_redir.pc", pc, 32'h100);
    chk("miss8_redir.req", {31'd0, mem_req}, 32'd1);
    chk("miss8_redir.addr", mem_addr, 32'h8);
    tick();
    chk("miss8_hold.addr", mem_addr, 32'h8);
    mem_valid = 1'b1; mem_data = model(32'h8); tick(); mem_valid = 1'b0;
    chk("miss8_fill.req", {31'd0, mem_req}, 32'd0);
    chk("miss8_fill.pc", pc, 32'h100);
    tick();
    chk("miss100.req", {31'd0, mem_req}, 32'd1);
    chk("miss100.addr", mem_addr, 32'h100);
    mem_valid = 1'b1; mem_data = model(32'h100); tick(); mem_valid = 1'b0;
    tick();
    chk("miss100.inst", inst_out, model(32'h100));
    chk("miss100.pc", pc, 32'h100);
    redirect = 1'b1; redirect_addr = 32'h8; tick(); redirect = 1'b0;
    chk("hit8.pc", pc, 32'h8);
    tick();
    chk("hit8.ready", {31'd0, inst_ready}, 32'd1);
    chk("hit8.inst", inst_out, model(32'h8));
    chk("hit8.no_req", {31'd0, mem_req}, 32'd0);

    // Freeze mid-miss, then reset mid-miss.
    redirect = 1'b1; redirect_addr = 32'h200; tick(); redirect = 1'b0;
    tick();
    chk("frz.req", {31'd0, mem_req}, 32'd1);
    rdy = 1'b0; redirect = 1'b1; redirect_addr = 32'h500; mem_valid = 1'b1; mem_data = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("frz.hold_req", {31'd0, mem_req}, 32'd1);
      chk("frz.hold_addr", mem_addr, 32'h200);
      chk("frz.hold_pc", pc, 32'h200);
    end
    redirect = 1'b0; mem_valid = 1'b0; rdy = 1'b1; rst = 1'b1; tick();
    chk("rst_miss.req", {31'd0, mem_req}, 32'd0);
    chk("rst_miss.pc", pc, 32'h0);
    chk("rst_miss.ready", {31'd0, inst_ready}, 32'd0);
    rst = 1'b0; tick();
    chk("rst_inv0.req", {31'd0, mem_req}, 32'd1);
    chk("rst_inv0.addr", mem_addr, 32'h0);
    mem_valid = 1'b1; mem_data = model(32'h0); tick(); mem_valid = 1'b0;
    tick();
    chk("rst_fill0.inst", inst_out, model(32'h0));
    need_inst = 1'b0; tick(); need_inst = 1'b1;
    tick();
    chk("rst_inv1.req", {31'd0, mem_req}, 32'd1);
    chk("rst_inv1.addr", mem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
